// File: rtl/eprisc_uart_stimulus.sv
// UART frame generator: byte FIFO feeding a serialiser with configurable
// frame format, bit period, inter-frame gap and optional CTS gating.
module eprisc_uart_stimulus #(
   parameter int unsigned CLKS_PER_BIT = 256,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned IDLE_BITS    = 0,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned USE_CTS      = 0
) (
   input  logic                 iBoardClock,
   input  logic                 iBoardReset,
   input  logic [DATA_BITS-1:0] iWriteData,
   input  logic                 iWriteStrobe,
   input  logic                 iCTS,
   output logic                 oSerialTX,
   output logic                 oFull,
   output logic                 oEmpty,
   output logic                 oBusy,
   output logic                 oFrameDone,
   output logic                 oOverflow
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned IW   = 4;

   localparam logic [CW-1:0]   BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0]   LAST_DATA  = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0]   LAST_STOP  = IW'(STOP_BITS - 1);
   localparam logic [IW-1:0]   LAST_IDLE  = IW'(IDLE_BITS - 1);
   localparam logic [CNTW-1:0] DEPTH_CNT  = CNTW'(FIFO_DEPTH);

   // Reject unsupported configurations at elaboration
   if (CLKS_PER_BIT < 2) begin : gBadClks
      $error("CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadData
      $error("DATA_BITS must be 5..9");
   end
   if (PARITY > 2) begin : gBadParity
      $error("PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
      $error("STOP_BITS must be 1 or 2");
   end
   if (IDLE_BITS > 15) begin : gBadIdle
      $error("IDLE_BITS must be 0..15");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end
   if (USE_CTS > 1) begin : gBadCts
      $error("USE_CTS must be 0 or 1");
   end

   typedef enum logic [2:0] {
      stIdle, stStart, stData, stParity, stStop, stGap
   } txState_t;

   txState_t             state;
   logic [CW-1:0]        bitCnt;
   logic [IW-1:0]        bitIdx;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 parBit;

   logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
   logic [AW-1:0]        wrPtr;
   logic [AW-1:0]        rdPtr;
   logic [CNTW-1:0]      fifoCount;
   logic [CNTW-1:0]      nextCount;

   logic                 fifoFull;
   logic                 fifoNotEmpty;
   logic                 ctsOk;
   logic                 bitEnd;
   logic                 frameEnd;
   logic                 pop;
   logic                 pushOk;
   logic [DATA_BITS-1:0] headData;
   logic                 headParity;

   // Pop/push decisions and FIFO occupancy for this cycle
   always_comb begin
      fifoFull     = (fifoCount == DEPTH_CNT);
      fifoNotEmpty = (fifoCount != '0);
      ctsOk        = (USE_CTS == 0) || iCTS;
      bitEnd       = (bitCnt == '0);
      frameEnd     = bitEnd &&
                     ((state == stStop && bitIdx == LAST_STOP && IDLE_BITS == 0) ||
                      (state == stGap  && bitIdx == LAST_IDLE));
      pop          = fifoNotEmpty && ctsOk && (state == stIdle || frameEnd);
      pushOk       = iWriteStrobe && (!fifoFull || pop);
      headData     = fifoMem[rdPtr];
      headParity   = (PARITY == 1) ? ~^headData : ^headData;
      nextCount    = fifoCount;
      case ({pushOk, pop})
         2'b10:   nextCount = fifoCount + CNTW'(1);
         2'b01:   nextCount = fifoCount - CNTW'(1);
         default: nextCount = fifoCount;
      endcase
   end

   // FIFO storage (no reset needed: slots are only read after being written)
   always_ff @(posedge iBoardClock) begin
      if (pushOk) fifoMem[wrPtr] <= iWriteData;
   end

   // FIFO pointers, occupancy flags and overflow pulse
   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
         oFull     <= 1'b0;
         oEmpty    <= 1'b1;
         oOverflow <= 1'b0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + AW'(1);
         if (pop)    rdPtr <= rdPtr + AW'(1);
         fifoCount <= nextCount;
         oFull     <= (nextCount == DEPTH_CNT);
         oEmpty    <= (nextCount == '0);
         oOverflow <= iWriteStrobe && fifoFull && !pop;
      end
   end

   // Frame sequencer; a pop always launches a start bit, even on the last mark edge
   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         state      <= stIdle;
         bitCnt     <= '0;
         bitIdx     <= '0;
         shiftReg   <= '0;
         parBit     <= 1'b0;
         oSerialTX  <= 1'b1;
         oBusy      <= 1'b0;
         oFrameDone <= 1'b0;
      end else begin
         oFrameDone <= 1'b0;
         if (pop) begin
            state      <= stStart;
            bitCnt     <= BIT_RELOAD;
            shiftReg   <= headData;
            parBit     <= headParity;
            oSerialTX  <= 1'b0;
            oBusy      <= 1'b1;
            oFrameDone <= frameEnd;
         end else if (state != stIdle) begin
            if (!bitEnd) begin
               bitCnt <= bitCnt - CW'(1);
            end else begin
               bitCnt <= BIT_RELOAD;
               case (state)
                  stStart: begin
                     state     <= stData;
                     oSerialTX <= shiftReg[0];
                     shiftReg  <= {1'b0, shiftReg[DATA_BITS-1:1]};
                     bitIdx    <= '0;
                  end
                  stData: begin
                     if (bitIdx == LAST_DATA) begin
                        bitIdx <= '0;
                        if (PARITY != 0) begin
                           state     <= stParity;
                           oSerialTX <= parBit;
                        end else begin
                           state     <= stStop;
                           oSerialTX <= 1'b1;
                        end
                     end else begin
                        oSerialTX <= shiftReg[0];
                        shiftReg  <= {1'b0, shiftReg[DATA_BITS-1:1]};
                        bitIdx    <= bitIdx + IW'(1);
                     end
                  end
                  stParity: begin
                     state     <= stStop;
                     oSerialTX <= 1'b1;
                     bitIdx    <= '0;
                  end
                  stStop: begin
                     if (bitIdx == LAST_STOP) begin
                        bitIdx <= '0;
                        if (IDLE_BITS == 0) begin
                           state      <= stIdle;
                           oBusy      <= 1'b0;
                           oFrameDone <= 1'b1;
                        end else begin
                           state <= stGap;
                        end
                     end else begin
                        bitIdx <= bitIdx + IW'(1);
                     end
                  end
                  stGap: begin
                     if (bitIdx == LAST_IDLE) begin
                        bitIdx     <= '0;
                        state      <= stIdle;
                        oBusy      <= 1'b0;
                        oFrameDone <= 1'b1;
                     end else begin
                        bitIdx <= bitIdx + IW'(1);
                     end
                  end
                  default: begin
                     state     <= stIdle;
                     oSerialTX <= 1'b1;
                     oBusy     <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_eprisc_uart_stimulus.sv
// Directed bench for eprisc_uart_stimulus: four instances cover 8N1 with CTS,
// 8E2 + 3 idle bits, 8O2 + 3 idle bits, and 7O1 at 2 clocks per bit.
`timescale 1ns/1ps
module tb_eprisc_uart_stimulus;

   logic       clk = 1'b0;
   logic       rstN;
   logic       cts;
   logic [8:0] wrData;
   logic [3:0] stb;
   logic [1:0] sel;

   logic [3:0] txV, fullV, emptyV, busyV, doneV, ovfV;

   int errCount   = 0;
   int checkCount = 0;
   logic fullSeenA = 1'b0;

   always #5 clk = ~clk;

   // Instance 0: 8N1, 4 clk/bit, CTS gated
   eprisc_uart_stimulus #(.CLKS_PER_BIT(4), .USE_CTS(1)) uA (
      .iBoardClock(clk), .iBoardReset(rstN), .iWriteData(wrData[7:0]),
      .iWriteStrobe(stb[0]), .iCTS(cts), .oSerialTX(txV[0]), .oFull(fullV[0]),
      .oEmpty(emptyV[0]), .oBusy(busyV[0]), .oFrameDone(doneV[0]), .oOverflow(ovfV[0]));

   // Instance 1: 8E2, 3 idle bits
   eprisc_uart_stimulus #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .IDLE_BITS(3)) uB (
      .iBoardClock(clk), .iBoardReset(rstN), .iWriteData(wrData[7:0]),
      .iWriteStrobe(stb[1]), .iCTS(cts), .oSerialTX(txV[1]), .oFull(fullV[1]),
      .oEmpty(emptyV[1]), .oBusy(busyV[1]), .oFrameDone(doneV[1]), .oOverflow(ovfV[1]));

   // Instance 2: 8O2, 3 idle bits
   eprisc_uart_stimulus #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .IDLE_BITS(3)) uC (
      .iBoardClock(clk), .iBoardReset(rstN), .iWriteData(wrData[7:0]),
      .iWriteStrobe(stb[2]), .iCTS(cts), .oSerialTX(txV[2]), .oFull(fullV[2]),
      .oEmpty(emptyV[2]), .oBusy(busyV[2]), .oFrameDone(doneV[2]), .oOverflow(ovfV[2]));

   // Instance 3: 7O1, 2 clk/bit (10-bit frame = 20 clk)
   eprisc_uart_stimulus #(.CLKS_PER_BIT(2), .DATA_BITS(7), .PARITY(1)) uD (
      .iBoardClock(clk), .iBoardReset(rstN), .iWriteData(wrData[6:0]),
      .iWriteStrobe(stb[3]), .iCTS(cts), .oSerialTX(txV[3]), .oFull(fullV[3]),
      .oEmpty(emptyV[3]), .oBusy(busyV[3]), .oFrameDone(doneV[3]), .oOverflow(ovfV[3]));

   // Sticky record of instance 0 ever reporting full
   always @(negedge clk) if (fullV[0] === 1'b1) fullSeenA <= 1'b1;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the strobe is sampled by the next posedge
   task automatic pushByte(input logic [8:0] d);
      wrData   = d;
      stb[sel] = 1'b1;
      @(negedge clk);
      stb      = '0;
   endtask

   // Advance until the selected line falls, bounded
   task automatic waitFall(input int maxCyc, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (txV[sel] !== 1'b0 && n < maxCyc);
      checkVal({tag, ".fall"}, 32'(txV[sel]), 32'd0);
   endtask

   // Entered at the negedge where the start bit is first seen; leaves at the
   // negedge just after the frame-ending edge.
   task automatic checkFrame(input string tag, input logic [15:0] vec,
                             input int nbits, input int cpb);
      int doneSeen = 0;
      for (int t = 0; t < nbits * cpb; t++) begin
         if (t > 0) begin
            @(negedge clk);
            if (doneV[sel] === 1'b1) doneSeen++;
         end
         if (t % cpb == 0 || t % cpb == cpb - 1)
            checkVal($sformatf("%s.b%0d.t%0d", tag, t / cpb, t), 32'(txV[sel]), 32'(vec[t / cpb]));
         if (t == cpb) checkVal({tag, ".busy"}, 32'(busyV[sel]), 32'd1);
      end
      @(negedge clk);
      checkVal({tag, ".doneEarly"}, 32'(doneSeen), 32'd0);
      checkVal({tag, ".done"}, 32'(doneV[sel]), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errCount, checkCount);
      $fatal(1);
   end

   initial begin
      rstN = 1'b0; cts = 1'b0; stb = '0; wrData = '0; sel = 2'd0;
      #12;
      // Reset state
      checkVal("rst.tx",    32'(txV[0]),    32'd1);
      checkVal("rst.full",  32'(fullV[0]),  32'd0);
      checkVal("rst.empty", 32'(emptyV[0]), 32'd1);
      checkVal("rst.busy",  32'(busyV[0]),  32'd0);
      checkVal("rst.done",  32'(doneV[0]),  32'd0);
      checkVal("rst.ovf",   32'(ovfV[0]),   32'd0);
      @(negedge clk); rstN = 1'b1;
      @(negedge clk);

      // T1: 0x31 8N1 -> {stop, 0x31, start} = 0x262; start one edge after push
      cts = 1'b1;
      pushByte(9'h031);
      checkVal("T1.preStart", 32'(txV[0]), 32'd1);
      checkVal("T1.notEmpty", 32'(emptyV[0]), 32'd0);
      @(negedge clk);
      checkVal("T1.latency", 32'(txV[0]), 32'd0);
      checkFrame("T1", 16'h0262, 10, 4);
      checkVal("T1.idle", 32'(txV[0]), 32'd1);
      checkVal("T1.busyOff", 32'(busyV[0]), 32'd0);
      checkVal("T1.empty", 32'(emptyV[0]), 32'd1);
      @(negedge clk);
      checkVal("T1.donePulse", 32'(doneV[0]), 32'd0);

      // T2: three contiguous frames 0x2E, 0x41, 0x0D
      fullSeenA = 1'b0;
      fork
         begin pushByte(9'h02E); pushByte(9'h041); pushByte(9'h00D); end
         begin
            waitFall(20, "T2");
            checkFrame("T2a", 16'h025C, 10, 4);
            checkVal("T2.contig1", 32'(txV[0]), 32'd0);
            checkVal("T2.notEmpty", 32'(emptyV[0]), 32'd0);
            checkFrame("T2b", 16'h0282, 10, 4);
            checkVal("T2.contig2", 32'(txV[0]), 32'd0);
            checkVal("T2.emptyRise", 32'(emptyV[0]), 32'd1);
            checkFrame("T2c", 16'h021A, 10, 4);
            checkVal("T2.idle", 32'(txV[0]), 32'd1);
         end
      join
      checkVal("T2.neverFull", 32'(fullSeenA), 32'd0);

      // T3: CTS low holds the queue; fifth push overflows
      cts = 1'b0;
      pushByte(9'h011); pushByte(9'h022); pushByte(9'h033);
      checkVal("T3.notFull3", 32'(fullV[0]), 32'd0);
      pushByte(9'h044);
      checkVal("T3.full4", 32'(fullV[0]), 32'd1);
      checkVal("T3.noOvf4", 32'(ovfV[0]), 32'd0);
      pushByte(9'h055);
      checkVal("T3.ovf5", 32'(ovfV[0]), 32'd1);
      @(negedge clk);
      checkVal("T3.ovfPulse", 32'(ovfV[0]), 32'd0);
      checkVal("T3.held", 32'(txV[0]), 32'd1);
      checkVal("T3.heldBusy", 32'(busyV[0]), 32'd0);
      cts = 1'b1;
      waitFall(10, "T3");
      checkFrame("T3a", 16'h0222, 10, 4);
      checkVal("T3.contig1", 32'(txV[0]), 32'd0);
      checkFrame("T3b", 16'h0244, 10, 4);
      checkVal("T3.contig2", 32'(txV[0]), 32'd0);
      checkFrame("T3c", 16'h0266, 10, 4);
      checkVal("T3.contig3", 32'(txV[0]), 32'd0);
      checkFrame("T3d", 16'h0288, 10, 4);
      checkVal("T3.idle", 32'(txV[0]), 32'd1);
      checkVal("T3.empty", 32'(emptyV[0]), 32'd1);

      // T5: reset during the third data bit (0x31 bit2 = 0)
      pushByte(9'h031); pushByte(9'h00D);
      checkVal("T5.start", 32'(txV[0]), 32'd0);
      repeat (13) @(negedge clk);
      checkVal("T5.dataBit2", 32'(txV[0]), 32'd0);
      checkVal("T5.queued", 32'(emptyV[0]), 32'd0);
      #1 rstN = 1'b0;
      #1;
      checkVal("T5.asyncTx", 32'(txV[0]), 32'd1);
      checkVal("T5.asyncEmpty", 32'(emptyV[0]), 32'd1);
      checkVal("T5.asyncBusy", 32'(busyV[0]), 32'd0);
      @(negedge clk);
      checkVal("T5.noDone", 32'(doneV[0]), 32'd0);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      checkVal("T5.quietTx", 32'(txV[0]), 32'd1);
      checkVal("T5.quietDone", 32'(doneV[0]), 32'd0);
      pushByte(9'h00D);
      @(negedge clk);
      checkVal("T5.latency", 32'(txV[0]), 32'd0);
      checkFrame("T5", 16'h021A, 10, 4);
      checkVal("T5.idle", 32'(txV[0]), 32'd1);

      // T4 even: 0x41 -> parity 0, 2 stop + 3 idle = 5 mark bits, frame 0x7C82
      sel = 2'd1;
      fork
         begin pushByte(9'h041); pushByte(9'h041); end
         begin
            waitFall(20, "T4e");
            checkFrame("T4e1", 16'h7C82, 15, 4);
            checkVal("T4e.next", 32'(txV[1]), 32'd0);
            checkFrame("T4e2", 16'h7C82, 15, 4);
            checkVal("T4e.idle", 32'(txV[1]), 32'd1);
         end
      join

      // T4 odd: same byte -> parity 1, frame 0x7E82
      sel = 2'd2;
      pushByte(9'h041);
      @(negedge clk);
      checkVal("T4o.latency", 32'(txV[2]), 32'd0);
      checkFrame("T4o", 16'h7E82, 15, 4);
      checkVal("T4o.idle", 32'(txV[2]), 32'd1);

      // T6: 7O1; push while full on the pop edge is accepted
      sel = 2'd3;
      fork
         begin
            pushByte(9'h07F); pushByte(9'h07F); pushByte(9'h07F);
            pushByte(9'h07F); pushByte(9'h07F);
            checkVal("T6.full", 32'(fullV[3]), 32'd1);
            repeat (16) @(negedge clk);
            checkVal("T6.fullBefore", 32'(fullV[3]), 32'd1);
            pushByte(9'h001);
            checkVal("T6.noOvf", 32'(ovfV[3]), 32'd0);
            checkVal("T6.stillFull", 32'(fullV[3]), 32'd1);
         end
         begin
            waitFall(10, "T6");
            checkFrame("T6a", 16'h02FE, 10, 2);
            for (int k = 0; k < 4; k++) begin
               checkVal($sformatf("T6.contig%0d", k), 32'(txV[3]), 32'd0);
               checkFrame($sformatf("T6m%0d", k), 16'h02FE, 10, 2);
            end
            checkVal("T6.contigLast", 32'(txV[3]), 32'd0);
            checkFrame("T6z", 16'h0202, 10, 2);
            checkVal("T6.idle", 32'(txV[3]), 32'd1);
            checkVal("T6.empty", 32'(emptyV[3]), 32'd1);
         end
      join

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
